stream_rx_buffer: RTL and testbench

//  Receiving end of the registered data/valid stream produced by our datapath

---
 rtl/stream_pkg.sv | 16 +
 rtl/rx_fifo_mem.sv | 25 ++
 rtl/stream_rx_buffer.sv | 110 +++++++++++
 tb/tb_stream_rx_buffer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared types, widths and sizing helpers for the stream receive buffer.
package stream_pkg;

    localparam int DROP_CNT_W = 8;

    typedef struct packed {
        logic                  ovf;
        logic [DROP_CNT_W-1:0] drops;
    } rx_status_t;

    // Pointer width: one extra bit beyond the index distinguishes full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// DEPTH x WIDTH storage array: one synchronous write port, asynchronous read port.
module rx_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage is deliberately not reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/stream_rx_buffer.sv
// Captures free-running data/valid beats into a small FIFO and re-presents them
// on a valid/ready interface, counting beats that arrive while full.
module stream_rx_buffer
    import stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [DROP_CNT_W-1:0]    drop_cnt,
    input  logic                     clr_status
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};
    localparam logic [DROP_CNT_W-1:0] DROP_ONE = DROP_CNT_W'(1);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    rx_status_t       status_q, status_d;

    logic             empty_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic             write_s;
    logic             drop_s;
    logic [WIDTH-1:0] rd_data_s;

    // Occupancy is implied entirely by the pointer difference.
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign push_s  = in_valid & enable;
    assign pop_s   = ~empty_s & out_ready;
    assign write_s = push_s & (~full_s | pop_s);
    assign drop_s  = push_s & full_s & ~pop_s;

    rx_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (write_s),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_data_s)
    );

    // Next-state for pointers and sticky status; a drop overrides a same-cycle clear.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        status_d = status_q;
        if (write_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (clr_status) begin
            status_d.ovf   = drop_s;
            status_d.drops = drop_s ? DROP_ONE : {DROP_CNT_W{1'b0}};
        end else if (drop_s) begin
            status_d.ovf   = 1'b1;
            status_d.drops = (status_q.drops == DROP_MAX) ? DROP_MAX
                                                          : status_q.drops + DROP_ONE;
        end else begin
            status_d = status_q;
        end
    end

    // State registers; rst_n is expected to be released synchronously upstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            status_q <= '{ovf: 1'b0, drops: {DROP_CNT_W{1'b0}}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            status_q <= status_d;
        end
    end

    // Outputs depend only on registered state, so reset clears them at once.
    assign out_valid = ~empty_s;
    assign out_data  = empty_s ? {WIDTH{1'b0}} : rd_data_s;
    assign level     = wr_ptr_q - rd_ptr_q;
    assign overflow  = status_q.ovf;
    assign drop_cnt  = status_q.drops;

endmodule

// File: tb/tb_stream_rx_buffer.sv
// Self-checking bench: queue-based reference model, directed scenarios, random traffic.
module tb_stream_rx_buffer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = 8'h00;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       level;
    logic             overflow;
    logic [7:0]       drop_cnt;
    logic             clr_status = 1'b0;

    int vectors = 0;
    int fails   = 0;

    logic [WIDTH-1:0] mq[$];
    bit               m_ovf = 1'b0;
    int               m_drops = 0;

    always #5 clk = ~clk;

    stream_rx_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .level      (level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .clr_status (clr_status)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        mq.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
    endfunction

    // Advance one clock and apply the FIFO rules to the model.
    task automatic step();
        int  pre;
        bit  pu, po, drop;
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            pre  = mq.size();
            pu   = in_valid & enable;
            po   = (pre != 0) && out_ready;
            drop = 1'b0;
            if (po) void'(mq.pop_front());
            if (pu) begin
                if (pre < DEPTH || po) mq.push_back(in_data);
                else drop = 1'b1;
            end
            if (clr_status) begin
                m_ovf   = 1'b0;
                m_drops = 0;
            end
            if (drop) begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end
        end
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop_expect(input logic [7:0] d);
        check("drain_data", {24'h0, out_data}, {24'h0, d});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("out_valid", {31'h0, out_valid}, {31'h0, mq.size() != 0});
        check("out_data", {24'h0, out_data}, (mq.size() != 0) ? {24'h0, mq[0]} : 32'h0);
        check("level", {29'h0, level}, mq.size());
        check("overflow", {31'h0, overflow}, {31'h0, m_ovf});
        check("drop_cnt", {24'h0, drop_cnt}, m_drops);
    end

    initial begin
        int exp_next;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // 1: single beat latency
        push(8'hA5);
        check("t1_valid", {31'h0, out_valid}, 32'h1);
        check("t1_data", {24'h0, out_data}, 32'hA5);
        check("t1_level", {29'h0, level}, 32'h1);
        pop_expect(8'hA5);

        // 2: overfill, one drop
        for (int i = 1; i <= 5; i++) push(8'(i * 8'h11));
        check("t2_level", {29'h0, level}, 32'h4);
        check("t2_ovf", {31'h0, overflow}, 32'h1);
        check("t2_drops", {24'h0, drop_cnt}, 32'h1);
        pop_expect(8'h11); pop_expect(8'h22); pop_expect(8'h33); pop_expect(8'h44);
        check("t2_empty", {29'h0, level}, 32'h0);

        // 3: push into full while popping
        for (int i = 1; i <= 4; i++) push(8'(i * 8'h11));
        out_ready = 1'b1;
        push(8'h66);
        out_ready = 1'b0;
        check("t3_level", {29'h0, level}, 32'h4);
        check("t3_head", {24'h0, out_data}, 32'h22);
        check("t3_drops", {24'h0, drop_cnt}, 32'h1);
        pop_expect(8'h22); pop_expect(8'h33); pop_expect(8'h44); pop_expect(8'h66);

        // 4: streaming push+pop, pointers wrap
        exp_next  = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (out_valid) begin
                check("t4_order", {24'h0, out_data}, exp_next);
                exp_next++;
            end
            in_valid = (i < 10);
            in_data  = 8'(i);
            step();
            check("t4_level_le1", {31'h0, level <= 3'd1}, 32'h1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("t4_count", exp_next, 32'd10);

        // 5: enable low ignores beats, then clear status
        enable   = 1'b0;
        in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        enable   = 1'b1;
        check("t5_level", {29'h0, level}, 32'h0);
        check("t5_ovf", {31'h0, overflow}, 32'h1);
        check("t5_drops", {24'h0, drop_cnt}, 32'h1);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        check("t5_clr_ovf", {31'h0, overflow}, 32'h0);
        check("t5_clr_drops", {24'h0, drop_cnt}, 32'h0);

        // 6: async reset mid-cycle, then saturation and clear-vs-drop
        for (int i = 0; i < 3; i++) push(8'(8'hC0 + i));
        check("t6_pre_level", {29'h0, level}, 32'h3);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", {31'h0, out_valid}, 32'h0);
        check("t6_rst_level", {29'h0, level}, 32'h0);
        model_clear();
        step();
        rst_n = 1'b1;
        step();
        in_valid = 1'b1;
        for (int i = 0; i < 304; i++) begin
            in_data = 8'(i);
            step();
        end
        in_valid = 1'b0;
        check("t6_sat", {24'h0, drop_cnt}, 32'hFF);
        clr_status = 1'b1;
        push(8'h77);
        clr_status = 1'b0;
        check("t6_clrdrop_ovf", {31'h0, overflow}, 32'h1);
        check("t6_clrdrop_cnt", {24'h0, drop_cnt}, 32'h1);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            enable     = ($urandom_range(7) != 0);
            in_valid   = ($urandom_range(3) != 0);
            in_data    = 8'($urandom);
            out_ready  = ($urandom_range(1) != 0);
            clr_status = ($urandom_range(31) == 0);
            step();
        end
        in_valid   = 1'b0;
        clr_status = 1'b0;
        out_ready  = 1'b1;
        repeat (6) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
